// File: rtl/cfg_reg_pkg.sv
// cfg_reg_pkg: shared state encoding, address map bases and error codes
package cfg_reg_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;
  localparam int CFG_BASE = 0;
  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_ACCESS = 1'b1;
  function automatic int status_base(input int num_cfg);
    return CFG_BASE + num_cfg;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting after the last-grant pointer
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);
  // scan from farthest to nearest so the requester closest after ptr wins
  always_comb begin
    int j;
    j = 0;
    gnt = '0;
    idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (req[j]) begin
        gnt = NUM_REQ'(1) << j;
        idx = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/cfg_reg_arbiter.sv
// cfg_reg_arbiter: round-robin shared access to the config bank and status bank
module cfg_reg_arbiter
  import cfg_reg_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int NUM_CFG = 8,
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr,
  input  logic [NUM_REQ*REG_WIDTH-1:0]   wdata,
  output logic [NUM_REQ-1:0]             ack,
  output logic [REG_WIDTH-1:0]           rdata,
  output logic                           err,
  output logic                           busy,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  output logic [NUM_CFG*REG_WIDTH-1:0]   config_regs
);
  localparam int IDX_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CIW = NUM_CFG > 1 ? $clog2(NUM_CFG) : 1;
  localparam int SIW = NUM_STATUS > 1 ? $clog2(NUM_STATUS) : 1;
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] STA_LO = AW1'(status_base(NUM_CFG));
  localparam logic [ADDR_WIDTH:0] STA_HI = AW1'(status_base(NUM_CFG) + NUM_STATUS);
  state_t state, state_nx;
  logic [IDX_W-1:0] ptr, arb_idx;
  logic [NUM_REQ-1:0] arb_gnt, cap_gnt;
  logic cap_we;
  logic [ADDR_WIDTH-1:0] cap_addr, req_addr;
  logic [REG_WIDTH-1:0] cap_wdata, req_wdata, rd_val;
  logic [REG_WIDTH-1:0] cfg_q [NUM_CFG];
  logic [REG_WIDTH-1:0] sta_w [NUM_STATUS];
  logic [ADDR_WIDTH:0] a_ext;
  logic [CIW-1:0] cfg_idx;
  logic [SIW-1:0] sta_idx;
  logic is_cfg, is_sta, acc_err, wr_ok;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req(req),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );
  for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
    assign config_regs[g*REG_WIDTH +: REG_WIDTH] = cfg_q[g];
  end
  for (genvar g = 0; g < NUM_STATUS; g++) begin : g_sta
    assign sta_w[g] = status_regs[g*REG_WIDTH +: REG_WIDTH];
  end
  assign req_addr = addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign req_wdata = wdata[arb_idx*REG_WIDTH +: REG_WIDTH];
  assign busy = state != IDLE;
  // decode the captured access against the address map
  always_comb begin
    a_ext = {1'b0, cap_addr};
    is_cfg = a_ext < STA_LO;
    is_sta = !is_cfg && a_ext < STA_HI;
    cfg_idx = CIW'(cap_addr);
    sta_idx = SIW'(a_ext - STA_LO);
    acc_err = (is_cfg || (is_sta && !cap_we)) ? ERR_NONE : ERR_ACCESS;
    wr_ok = cap_we && is_cfg;
    rd_val = acc_err ? '0 : is_cfg ? cfg_q[cfg_idx] : sta_w[sta_idx];
  end
  // IDLE -> GRANT on any request, then ACK, then back to IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = |req ? GRANT : IDLE;
      GRANT:   state_nx = ACK;
      default: state_nx = IDLE;
    endcase
  end
  // state, capture, commit and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= IDX_W'(NUM_REQ - 1);
      cap_gnt <= '0;
      cap_we <= 1'b0;
      cap_addr <= '0;
      cap_wdata <= '0;
      ack <= '0;
      err <= 1'b0;
      rdata <= '0;
      for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
    end else begin
      state <= state_nx;
      ack <= '0;
      if (state == IDLE && |req) begin
        ptr <= arb_idx;
        cap_gnt <= arb_gnt;
        cap_we <= we[arb_idx];
        cap_addr <= req_addr;
        cap_wdata <= req_wdata;
      end
      if (state == GRANT) begin
        ack <= cap_gnt;
        err <= acc_err;
        rdata <= rd_val;
        if (wr_ok) cfg_q[cfg_idx] <= cap_wdata;
      end
    end
  end
endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// tb_cfg_reg_arbiter: directed scenario tests for cfg_reg_arbiter
module tb_cfg_reg_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] req, we, ack;
  logic [9:0] addr;
  logic [15:0] wdata;
  logic [7:0] rdata;
  logic err, busy;
  logic [63:0] status_regs, config_regs;
  int vectors = 0;
  int miscompares = 0;
  cfg_reg_arbiter #(
    .NUM_REQ(2), .NUM_CFG(8), .NUM_STATUS(8), .REG_WIDTH(8), .ADDR_WIDTH(5)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err(err), .busy(busy),
    .status_regs(status_regs), .config_regs(config_regs)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic access(input int r, input logic w, input logic [4:0] a, input logic [7:0] d,
                        output int lat, output logic [1:0] ack_s, output logic [7:0] rd_s,
                        output logic err_s, output logic [63:0] cfg_s);
    req[r] = 1'b1;
    we[r] = w;
    addr[r*5 +: 5] = a;
    wdata[r*8 +: 8] = d;
    lat = -1;
    ack_s = 'x;
    rd_s = 'x;
    err_s = 1'bx;
    cfg_s = 'x;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (ack != 2'b00) begin
        lat = n;
        ack_s = ack;
        rd_s = rdata;
        err_s = err;
        cfg_s = config_regs;
        break;
      end
    end
    req[r] = 1'b0;
    step();
  endtask
  task automatic test_reset();
    vectors++;
    if (ack !== 2'b00 || busy !== 1'b0 || err !== 1'b0 || rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: ack=%b busy=%b err=%b rdata=%h, need 00/0/0/00", ack, busy, err, rdata);
    end
    vectors++;
    if (config_regs !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_cfg: got %h need 0", config_regs);
    end
  endtask
  task automatic test_write_cfg();
    int lat;
    logic [1:0] a;
    logic [7:0] rd;
    logic e;
    logic [63:0] c;
    access(0, 1'b1, 5'd3, 8'hA5, lat, a, rd, e, c);
    vectors++;
    if (lat !== 2 || a !== 2'b01 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_addr3_ack: lat=%0d ack=%b err=%b, need 2/01/0", lat, a, e);
    end
    vectors++;
    if (c !== 64'h00000000_A5000000) begin
      miscompares++;
      $display("FAIL wr_addr3_cfg: got %h need 00000000a5000000", c);
    end
    access(1, 1'b1, 5'd7, 8'h81, lat, a, rd, e, c);
    vectors++;
    if (lat !== 2 || a !== 2'b10 || e !== 1'b0 || c !== 64'h81000000_A5000000) begin
      miscompares++;
      $display("FAIL wr_addr7: lat=%0d ack=%b err=%b cfg=%h, need 2/10/0/81000000a5000000", lat, a, e, c);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_idle_after: busy=%b need 0", busy);
    end
  endtask
  task automatic test_read_status();
    int lat;
    logic [1:0] a;
    logic [7:0] rd;
    logic e;
    logic [63:0] c;
    access(0, 1'b0, 5'd3, 8'h00, lat, a, rd, e, c);
    vectors++;
    if (lat !== 2 || a !== 2'b01 || rd !== 8'hA5 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_cfg3: lat=%0d ack=%b rdata=%h err=%b, need 2/01/a5/0", lat, a, rd, e);
    end
    access(1, 1'b0, 5'd8, 8'h00, lat, a, rd, e, c);
    vectors++;
    if (lat !== 2 || a !== 2'b10 || rd !== 8'hCA || e !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_sta0: lat=%0d ack=%b rdata=%h err=%b, need 2/10/ca/0", lat, a, rd, e);
    end
  endtask
  task automatic test_round_robin();
    logic [1:0] exp_ack;
    req = 2'b11;
    we = 2'b11;
    addr = {5'd0, 5'd0};
    wdata = {8'h01, 8'h00};
    for (int n = 1; n <= 12; n++) begin
      step();
      exp_ack = (n == 2 || n == 8) ? 2'b01 : (n == 5 || n == 11) ? 2'b10 : 2'b00;
      vectors++;
      if (ack !== exp_ack) begin
        miscompares++;
        $display("FAIL rr_ack_c%0d: got %b need %b", n, ack, exp_ack);
      end
      if (exp_ack != 2'b00) begin
        vectors++;
        if (config_regs[7:0] !== (exp_ack == 2'b01 ? 8'h00 : 8'h01)) begin
          miscompares++;
          $display("FAIL rr_cfg0_c%0d: got %h need %h", n, config_regs[7:0], exp_ack == 2'b01 ? 8'h00 : 8'h01);
        end
      end
    end
    req = 2'b00;
    we = 2'b00;
    step();
    step();
  endtask
  task automatic test_errors();
    int lat;
    logic [1:0] a;
    logic [7:0] rd;
    logic e;
    logic [63:0] c;
    access(0, 1'b1, 5'd9, 8'h55, lat, a, rd, e, c);
    vectors++;
    if (lat !== 2 || a !== 2'b01 || e !== 1'b1 || rd !== 8'h00 || c !== 64'h81000000_A5000001) begin
      miscompares++;
      $display("FAIL err_wr_status: lat=%0d ack=%b err=%b rdata=%h cfg=%h, need 2/01/1/00/81000000a5000001", lat, a, e, rd, c);
    end
    access(1, 1'b0, 5'd20, 8'h00, lat, a, rd, e, c);
    vectors++;
    if (lat !== 2 || a !== 2'b10 || e !== 1'b1 || rd !== 8'h00 || c !== 64'h81000000_A5000001) begin
      miscompares++;
      $display("FAIL err_unmapped: lat=%0d ack=%b err=%b rdata=%h cfg=%h, need 2/10/1/00/81000000a5000001", lat, a, e, rd, c);
    end
    access(0, 1'b0, 5'd15, 8'h00, lat, a, rd, e, c);
    vectors++;
    if (lat !== 2 || e !== 1'b0 || rd !== 8'h5E) begin
      miscompares++;
      $display("FAIL rd_sta_last: lat=%0d err=%b rdata=%h, need 2/0/5e", lat, e, rd);
    end
    access(1, 1'b0, 5'd16, 8'h00, lat, a, rd, e, c);
    vectors++;
    if (lat !== 2 || e !== 1'b1 || rd !== 8'h00) begin
      miscompares++;
      $display("FAIL err_first_unmapped: lat=%0d err=%b rdata=%h, need 2/1/00", lat, e, rd);
    end
  endtask
  task automatic test_reset_in_grant();
    int lat;
    logic [1:0] a;
    req[0] = 1'b1;
    we[0] = 1'b1;
    addr[4:0] = 5'd1;
    wdata[7:0] = 8'h3C;
    step();
    vectors++;
    if (busy !== 1'b1 || ack !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_grant_busy: busy=%b ack=%b need 1/00", busy, ack);
    end
    rst = 1'b1;
    step();
    vectors++;
    if (ack !== 2'b00 || busy !== 1'b0 || config_regs !== 64'h0) begin
      miscompares++;
      $display("FAIL rst_grant_discard: ack=%b busy=%b cfg=%h need 00/0/0", ack, busy, config_regs);
    end
    req = 2'b00;
    rst = 1'b0;
    step();
    req = 2'b11;
    we = 2'b00;
    addr = 10'd0;
    lat = -1;
    a = 'x;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (ack != 2'b00) begin
        lat = n;
        a = ack;
        break;
      end
    end
    req = 2'b00;
    vectors++;
    if (lat !== 2 || a !== 2'b01) begin
      miscompares++;
      $display("FAIL rst_tie_r0: lat=%0d ack=%b need 2/01", lat, a);
    end
    step();
    step();
  endtask
  task automatic test_drop_in_grant();
    req[1] = 1'b1;
    we[1] = 1'b1;
    addr[9:5] = 5'd2;
    wdata[15:8] = 8'h7E;
    step();
    req[1] = 1'b0;
    step();
    vectors++;
    if (ack !== 2'b10 || config_regs !== 64'h00000000_007E0000) begin
      miscompares++;
      $display("FAIL drop_ack: ack=%b cfg=%h need 10/00000000007e0000", ack, config_regs);
    end
    step();
    vectors++;
    if (ack !== 2'b00 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_idle: ack=%b busy=%b need 00/0", ack, busy);
    end
    step();
    vectors++;
    if (busy !== 1'b0 || config_regs[23:16] !== 8'h7E) begin
      miscompares++;
      $display("FAIL drop_stay_idle: busy=%b cfg2=%h need 0/7e", busy, config_regs[23:16]);
    end
  endtask
  initial begin
    rst = 1'b1;
    req = '0;
    we = '0;
    addr = '0;
    wdata = '0;
    status_regs = 64'h5E000000_000000CA;
    step();
    step();
    test_reset();
    rst = 1'b0;
    step();
    test_write_cfg();
    test_read_status();
    test_round_robin();
    test_errors();
    test_reset_in_grant();
    test_drop_in_grant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cfg_reg_arbiter.md
# cfg_reg_arbiter

Owns the configuration register bank and shares it between several bus requesters, typically the SPI slave wrapper (requester 0) and on-chip logic such as a self-test or autoload engine (requester 1+). It also serves read access to the status register bank. Each access is a single read or write through a round-robin-arbitrated req/ack handshake. The block sits between the SPI front end and the `config_regs`/`status_regs` buses at the top level.

## Interface
- NUM_REQ, 2, number of requesters
- NUM_CFG, 8, number of read/write config registers
- NUM_STATUS, 8, number of read-only status registers
- REG_WIDTH, 8, register width in bits
- ADDR_WIDTH, 4, address width; must satisfy 2^ADDR_WIDTH ≥ NUM_CFG+NUM_STATUS

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester access request
- we  in  NUM_REQ  per-requester write enable (1 = write, 0 = read)
- addr  in  NUM_REQ*ADDR_WIDTH  per-requester address; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- wdata  in  NUM_REQ*REG_WIDTH  per-requester write data, same packing
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
- rdata  out  REG_WIDTH  read data, shared, valid while any ack bit is high
- err  out  1  access error flag, valid with ack
- busy  out  1  high in any state other than IDLE
- status_regs  in  NUM_STATUS*REG_WIDTH  status bank, register k at [k*REG_WIDTH +: REG_WIDTH]
- config_regs  out  NUM_CFG*REG_WIDTH  config bank, same packing

## Operation
- Address map:
  - addr < NUM_CFG selects config register addr (R/W).
  - NUM_CFG ≤ addr < NUM_CFG+NUM_STATUS selects status register addr−NUM_CFG (read-only).
  - Any other address is unmapped.
- Errors:
  - A write to a status register or any access to an unmapped address sets err=1 with ack.
  - On an error, no register changes and rdata=0.
- FSM states: IDLE, GRANT, ACK.
  - IDLE→GRANT when any req is high. The winner index, its we, addr and wdata are captured.
  - GRANT→ACK unconditionally. A captured legal write is committed on this edge. rdata and err are registered on this edge.
  - ACK→IDLE unconditionally. ack[winner]=1 only in ACK.
- Round robin:
  - A pointer holds the last granted index. The search for the next grant starts at pointer+1 (mod NUM_REQ).
  - The pointer updates on the IDLE→GRANT edge.
  - The reset value is NUM_REQ−1, so requester 0 wins the first tie.
- Requester rules:
  - Hold req, we, addr and wdata stable until ack is seen.
  - Drop req in the cycle after ack. A req still high then counts as a new request.
  - If req drops during GRANT, the captured access still completes and ack still pulses. The requester ignores it.
- Read of a config register returns its value before any write in the same access (there is none, since reads and writes are exclusive).
- Reset:
  - In any state, rst forces IDLE, ack=0, err=0, rdata=0, busy=0, all config_regs=0, and pointer=NUM_REQ−1.
  - A write captured in GRANT when rst asserts is discarded.

## Timing
- Latency: req high in IDLE at cycle 0 → GRANT in cycle 1 → ack, rdata and err valid in cycle 2.
- A committed write is visible on config_regs in cycle 2, coincident with ack.
- Throughput: one access per 3 cycles. IDLE is always visited between accesses.
- busy is high in cycles 1–2.
- rdata and err hold their last values outside ACK. Consumers qualify them with ack.
- status_regs is sampled on the GRANT→ACK edge only.
- Outputs are registered; there is no combinational path from req to ack.

## Structure
- Shared package `cfg_reg_pkg` holds:
  - the state enum (IDLE, GRANT, ACK);
  - address-decode helper constants (CFG_BASE=0, STATUS_BASE=NUM_CFG);
  - error code localparams.
- One natural sub-module, `rr_arbiter`:
  - NUM_REQ-wide request vector plus the last-grant pointer in; one-hot grant and encoded index out;
  - combinational, with the pointer register kept in the parent.
- Register storage, decode and FSM stay in `cfg_reg_arbiter`.

## Test plan
- Reset, then requester 0 writes addr 3 = 0xA5 → ack[0] in cycle 2, config_regs[31:24]=0xA5, err=0, all other config bytes 0x00.
- Requester 1 reads addr 8 with status_regs[7:0]=0xCA → ack[1] pulse, rdata=0xCA, err=0.
- req[0] and req[1] both high continuously, each writing its own index to addr 0 → grants alternate 0,1,0,1 starting with 0; each ack one cycle wide, 3 cycles apart.
- Write 0x55 to addr 9 (status), then read addr 15 (unmapped, NUM_CFG+NUM_STATUS=16 → mapped, so use ADDR_WIDTH=5 with addr 20) → err=1, rdata=0, config_regs unchanged.
- Requester 0 writes 0x3C to addr 1, with rst asserted during GRANT → no ack, config_regs all 0, FSM IDLE, next tie grants requester 0.
- Requester 1 drops req during GRANT of a write of 0x7E to addr 2 → ack[1] still pulses in cycle 2, config_regs[23:16]=0x7E, next access starts from IDLE.
